// File: rtl/vo_timing_ctrl.sv
// Video-output timing controller: holds live and shadow H/V sync-generator limits,
// validates committed shadow sets, applies them on frame boundaries and gates both generators.
module vo_timing_ctrl #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 752,
    parameter int unsigned H_BLANK      = 799,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 492,
    parameter int unsigned V_BLANK      = 524,
    parameter logic [1:0]  SYNC_POL     = 2'b00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic        i_enable,
    input  logic        i_cfg_we,
    input  logic [3:0]  i_cfg_addr,
    input  logic [11:0] i_cfg_data,
    input  logic [11:0] i_h_cnt,
    input  logic [11:0] i_v_cnt,
    output logic        o_h_clk_en,
    output logic        o_v_clk_en,
    output logic [11:0] o_h_active,
    output logic [11:0] o_h_sync_start,
    output logic [11:0] o_h_sync_end,
    output logic [11:0] o_h_blank,
    output logic [11:0] o_v_active,
    output logic [11:0] o_v_sync_start,
    output logic [11:0] o_v_sync_end,
    output logic [11:0] o_v_blank,
    output logic        o_h_sync_pol,
    output logic        o_v_sync_pol,
    output logic        o_cfg_busy,
    output logic        o_cfg_err,
    output logic        o_locked,
    output logic        o_frame_start
);

    localparam int unsigned CW = 12;

    localparam logic [3:0] A_H_ACTIVE = 4'd0;
    localparam logic [3:0] A_H_SSTART = 4'd1;
    localparam logic [3:0] A_H_SEND   = 4'd2;
    localparam logic [3:0] A_H_BLANK  = 4'd3;
    localparam logic [3:0] A_V_ACTIVE = 4'd4;
    localparam logic [3:0] A_V_SSTART = 4'd5;
    localparam logic [3:0] A_V_SEND   = 4'd6;
    localparam logic [3:0] A_V_BLANK  = 4'd7;
    localparam logic [3:0] A_POL      = 4'd8;
    localparam logic [3:0] A_COMMIT   = 4'd15;

    typedef struct packed {
        logic [CW-1:0] active;
        logic [CW-1:0] sync_start;
        logic [CW-1:0] sync_end;
        logic [CW-1:0] blank;
    } axis_t;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ALIGN,
        ST_RUN
    } state_t;

    localparam axis_t H_RST = {CW'(H_ACTIVE), CW'(H_SYNC_START), CW'(H_SYNC_END), CW'(H_BLANK)};
    localparam axis_t V_RST = {CW'(V_ACTIVE), CW'(V_SYNC_START), CW'(V_SYNC_END), CW'(V_BLANK)};

    state_t     state;
    axis_t      sh_h, sh_v, lv_h, lv_v;
    logic [1:0] sh_pol, lv_pol;

    logic h_wrap, f_wrap, run_c, at_origin, cfg_ok, wr_c, apply_c;

    function automatic logic axis_ok(input axis_t a);
        return (a.active < a.sync_start) && (a.sync_start < a.sync_end) && (a.sync_end < a.blank);
    endfunction

    // Dropping i_enable freezes the generators in that very cycle, not one cycle later.
    always_comb begin
        run_c     = (state != ST_OFF) && i_enable;
        h_wrap    = i_pix_en && (i_h_cnt == lv_h.blank);
        f_wrap    = h_wrap && (i_v_cnt == lv_v.blank);
        at_origin = i_pix_en && (i_h_cnt == CW'(0)) && (i_v_cnt == CW'(0));
        cfg_ok    = axis_ok(sh_h) && axis_ok(sh_v);
        wr_c      = i_cfg_we && !o_cfg_busy;
        apply_c   = o_cfg_busy && ((state == ST_OFF) || (run_c && f_wrap));
    end

    assign o_h_clk_en = run_c && i_pix_en;
    assign o_v_clk_en = run_c && h_wrap;

    // Shadow writes, commit validation and frame-boundary apply.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh_h       <= H_RST;
            sh_v       <= V_RST;
            sh_pol     <= SYNC_POL;
            lv_h       <= H_RST;
            lv_v       <= V_RST;
            lv_pol     <= SYNC_POL;
            o_cfg_busy <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            if (wr_c) begin
                case (i_cfg_addr)
                    A_H_ACTIVE: sh_h.active     <= i_cfg_data;
                    A_H_SSTART: sh_h.sync_start <= i_cfg_data;
                    A_H_SEND:   sh_h.sync_end   <= i_cfg_data;
                    A_H_BLANK:  sh_h.blank      <= i_cfg_data;
                    A_V_ACTIVE: sh_v.active     <= i_cfg_data;
                    A_V_SSTART: sh_v.sync_start <= i_cfg_data;
                    A_V_SEND:   sh_v.sync_end   <= i_cfg_data;
                    A_V_BLANK:  sh_v.blank      <= i_cfg_data;
                    A_POL:      sh_pol          <= i_cfg_data[1:0];
                    A_COMMIT: begin
                        if (cfg_ok) begin
                            o_cfg_busy <= 1'b1;
                            o_cfg_err  <= 1'b0;
                        end else begin
                            o_cfg_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (apply_c) begin
                lv_h       <= sh_h;
                lv_v       <= sh_v;
                lv_pol     <= sh_pol;
                o_cfg_busy <= 1'b0;
            end
        end
    end

    // Sequencer: OFF -> ALIGN waits for the generators to pass (0,0) -> RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_OFF;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            case (state)
                ST_OFF: begin
                    if (i_enable) state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!i_enable) begin
                        state <= ST_OFF;
                    end else if (at_origin) begin
                        state         <= ST_RUN;
                        o_locked      <= 1'b1;
                        o_frame_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state    <= ST_OFF;
                        o_locked <= 1'b0;
                    end else if (f_wrap) begin
                        o_frame_start <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_OFF;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_h_active     = lv_h.active;
    assign o_h_sync_start = lv_h.sync_start;
    assign o_h_sync_end   = lv_h.sync_end;
    assign o_h_blank      = lv_h.blank;
    assign o_v_active     = lv_v.active;
    assign o_v_sync_start = lv_v.sync_start;
    assign o_v_sync_end   = lv_v.sync_end;
    assign o_v_blank      = lv_v.blank;
    assign o_h_sync_pol   = lv_pol[0];
    assign o_v_sync_pol   = lv_pol[1];

endmodule

// File: tb/tb_vo_timing_ctrl.sv
// Bench for vo_timing_ctrl: the bench plays both sync generators and predicts
// frame_start cycles into a scoreboard queue that the per-cycle monitor drains.
module tb_vo_timing_ctrl;

    logic        i_clk, i_rst, i_pix_en, i_enable, i_cfg_we;
    logic [3:0]  i_cfg_addr;
    logic [11:0] i_cfg_data, i_h_cnt, i_v_cnt;
    logic        o_h_clk_en, o_v_clk_en;
    logic [11:0] o_h_active, o_h_sync_start, o_h_sync_end, o_h_blank;
    logic [11:0] o_v_active, o_v_sync_start, o_v_sync_end, o_v_blank;
    logic        o_h_sync_pol, o_v_sync_pol, o_cfg_busy, o_cfg_err, o_locked, o_frame_start;

    int unsigned cyc_n, n_cmp, n_err, k, hf;
    int unsigned fs_q[$];
    logic        s_he, s_ve;
    logic [11:0] s_hb, s_vb;

    vo_timing_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_en(i_pix_en), .i_enable(i_enable),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .i_h_cnt(i_h_cnt), .i_v_cnt(i_v_cnt),
        .o_h_clk_en(o_h_clk_en), .o_v_clk_en(o_v_clk_en),
        .o_h_active(o_h_active), .o_h_sync_start(o_h_sync_start),
        .o_h_sync_end(o_h_sync_end), .o_h_blank(o_h_blank),
        .o_v_active(o_v_active), .o_v_sync_start(o_v_sync_start),
        .o_v_sync_end(o_v_sync_end), .o_v_blank(o_v_blank),
        .o_h_sync_pol(o_h_sync_pol), .o_v_sync_pol(o_v_sync_pol),
        .o_cfg_busy(o_cfg_busy), .o_cfg_err(o_cfg_err),
        .o_locked(o_locked), .o_frame_start(o_frame_start)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock: generators step on the enables seen just before the edge; outputs checked at negedge.
    task automatic cyc();
        #1;
        s_he = o_h_clk_en;
        s_ve = o_v_clk_en;
        s_hb = o_h_blank;
        s_vb = o_v_blank;
        @(posedge i_clk);
        cyc_n++;
        #1;
        if (s_he) i_h_cnt = (i_h_cnt == s_hb) ? 12'd0 : i_h_cnt + 12'd1;
        if (s_ve) i_v_cnt = (i_v_cnt == s_vb) ? 12'd0 : i_v_cnt + 12'd1;
        @(negedge i_clk);
        while (fs_q.size() != 0 && fs_q[0] < cyc_n) chk("fs_missing", 0, fs_q.pop_front());
        if (o_frame_start) begin
            if (fs_q.size() == 0) chk("fs_unexpected", cyc_n, 0);
            else                  chk("fs_cycle", cyc_n, fs_q.pop_front());
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        i_cfg_we   = 1'b1;
        i_cfg_addr = a;
        i_cfg_data = d;
        cyc();
        i_cfg_we   = 1'b0;
    endtask

    task automatic wait_vpulse(input int unsigned budget);
        for (int i = 0; i < int'(budget); i++) begin
            cyc();
            if (o_v_clk_en) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_n = 0; n_cmp = 0; n_err = 0;
        i_rst = 1'b1; i_pix_en = 1'b1; i_enable = 1'b0;
        i_cfg_we = 1'b0; i_cfg_addr = 4'd0; i_cfg_data = 12'd0;
        i_h_cnt = 12'd0; i_v_cnt = 12'd0;

        // Reset state
        cyc(); cyc();
        chk("rst_h_active", o_h_active, 640);
        chk("rst_h_sstart", o_h_sync_start, 656);
        chk("rst_h_send", o_h_sync_end, 752);
        chk("rst_h_blank", o_h_blank, 799);
        chk("rst_v_active", o_v_active, 480);
        chk("rst_v_sstart", o_v_sync_start, 490);
        chk("rst_v_send", o_v_sync_end, 492);
        chk("rst_v_blank", o_v_blank, 524);
        chk("rst_pol", {o_v_sync_pol, o_h_sync_pol}, 0);
        chk("rst_busy", o_cfg_busy, 0);
        chk("rst_err", o_cfg_err, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_hen", o_h_clk_en, 0);
        i_rst = 1'b0;
        cyc();
        chk("off_hen", o_h_clk_en, 0);

        // Lock from (0,0) at default timing
        k = cyc_n;
        i_enable = 1'b1;
        fs_q.push_back(k + 2);
        cyc();
        chk("align_locked", o_locked, 0);
        chk("align_hen", o_h_clk_en, 1);
        cyc();
        chk("run_locked", o_locked, 1);
        wait_vpulse(1000);
        chk("vpulse_1", cyc_n, k + 800);
        wait_vpulse(1000);
        chk("vpulse_2", cyc_n, k + 1600);

        // Pixel enable low holds the H generator
        i_pix_en = 1'b0;
        #1;
        chk("pix_hen", o_h_clk_en, 0);
        chk("pix_ven", o_v_clk_en, 0);
        hf = i_h_cnt;
        cyc(); cyc();
        chk("pix_hold", i_h_cnt, hf);
        i_pix_en = 1'b1;

        // New timing committed mid-frame, applied on f_wrap
        wr(4'd0, 12'd800); wr(4'd1, 12'd840); wr(4'd2, 12'd968); wr(4'd3, 12'd1055);
        wr(4'd4, 12'd600); wr(4'd5, 12'd601); wr(4'd6, 12'd605); wr(4'd7, 12'd627);
        wr(4'd15, 12'd0);
        chk("commit_busy", o_cfg_busy, 1);
        chk("commit_err", o_cfg_err, 0);
        chk("pend_h_active", o_h_active, 640);
        wr(4'd0, 12'd123);
        k = cyc_n;
        i_h_cnt = 12'd795; i_v_cnt = 12'd524;
        fs_q.push_back(k + 5);
        repeat (4) cyc();
        chk("wrap_busy", o_cfg_busy, 1);
        chk("wrap_h_blank", o_h_blank, 799);
        chk("wrap_ven", o_v_clk_en, 1);
        cyc();
        chk("apply_busy", o_cfg_busy, 0);
        chk("apply_h_active", o_h_active, 800);
        chk("apply_h_sstart", o_h_sync_start, 840);
        chk("apply_h_send", o_h_sync_end, 968);
        chk("apply_h_blank", o_h_blank, 1055);
        chk("apply_v_active", o_v_active, 600);
        chk("apply_v_sstart", o_v_sync_start, 601);
        chk("apply_v_send", o_v_sync_end, 605);
        chk("apply_v_blank", o_v_blank, 627);
        chk("apply_hcnt", i_h_cnt, 0);
        chk("apply_vcnt", i_v_cnt, 0);
        k = cyc_n;
        wait_vpulse(1200);
        chk("vpulse_new", cyc_n, k + 1055);
        cyc();
        k = cyc_n;
        i_h_cnt = 12'd1050; i_v_cnt = 12'd627;
        fs_q.push_back(k + 6);
        repeat (6) cyc();
        chk("fwrap_new_h", i_h_cnt, 0);

        // Rejected commits: ordering violation, then equality at sync_end == blank
        wr(4'd1, 12'd600); wr(4'd15, 12'd0);
        chk("bad_err", o_cfg_err, 1);
        chk("bad_busy", o_cfg_busy, 0);
        chk("bad_live", o_h_sync_start, 840);
        wr(4'd1, 12'd840); wr(4'd6, 12'd627); wr(4'd15, 12'd0);
        chk("eq_err", o_cfg_err, 1);
        chk("eq_busy", o_cfg_busy, 0);

        // Commit landing on the f_wrap cycle waits for the next frame
        wr(4'd6, 12'd605); wr(4'd8, 12'd3);
        k = cyc_n;
        i_cfg_we = 1'b1; i_cfg_addr = 4'd15;
        i_h_cnt = 12'd1055; i_v_cnt = 12'd627;
        fs_q.push_back(k + 1);
        cyc();
        i_cfg_we = 1'b0;
        chk("cw_busy", o_cfg_busy, 1);
        chk("cw_err", o_cfg_err, 0);
        chk("cw_pol", {o_v_sync_pol, o_h_sync_pol}, 0);
        k = cyc_n;
        i_h_cnt = 12'd1053; i_v_cnt = 12'd627;
        fs_q.push_back(k + 3);
        cyc(); cyc();
        chk("cw_wait_busy", o_cfg_busy, 1);
        cyc();
        chk("cw_apply_busy", o_cfg_busy, 0);
        chk("cw_apply_pol", {o_v_sync_pol, o_h_sync_pol}, 3);
        chk("cw_apply_vsend", o_v_sync_end, 605);

        // Drop enable mid-line: enables off that cycle, counts frozen
        repeat (20) cyc();
        i_enable = 1'b0;
        #1;
        chk("drop_hen", o_h_clk_en, 0);
        chk("drop_ven", o_v_clk_en, 0);
        hf = i_h_cnt;
        cyc();
        chk("drop_locked", o_locked, 0);
        repeat (3) cyc();
        chk("drop_frozen", i_h_cnt, hf);

        // Re-enable from parked counts: ALIGN until (0,0)
        k = cyc_n;
        i_h_cnt = 12'd1000; i_v_cnt = 12'd627;
        i_enable = 1'b1;
        fs_q.push_back(k + 58);
        repeat (57) cyc();
        chk("realign_locked", o_locked, 0);
        cyc();
        chk("relock", o_locked, 1);

        // Enable fall coincides with f_wrap and a pending commit: OFF wins, apply in OFF
        wr(4'd8, 12'd0); wr(4'd0, 12'd700); wr(4'd15, 12'd0);
        chk("pend2_busy", o_cfg_busy, 1);
        i_h_cnt = 12'd1055; i_v_cnt = 12'd627;
        i_enable = 1'b0;
        cyc();
        chk("offwin_busy", o_cfg_busy, 1);
        chk("offwin_locked", o_locked, 0);
        chk("offwin_live", o_h_active, 800);
        cyc();
        chk("offapply_busy", o_cfg_busy, 0);
        chk("offapply_active", o_h_active, 700);
        chk("offapply_pol", {o_v_sync_pol, o_h_sync_pol}, 0);
        chk("offapply_hcnt", i_h_cnt, 1055);
        k = cyc_n;
        i_enable = 1'b1;
        fs_q.push_back(k + 3);
        cyc(); cyc();
        chk("re2_locked", o_locked, 0);
        cyc();
        chk("re2_lock", o_locked, 1);

        // Async reset with a commit pending
        repeat (10) cyc();
        wr(4'd0, 12'd650); wr(4'd15, 12'd0);
        chk("pend3_busy", o_cfg_busy, 1);
        i_rst = 1'b1;
        i_enable = 1'b0;
        #1;
        chk("arst_busy", o_cfg_busy, 0);
        chk("arst_locked", o_locked, 0);
        chk("arst_hen", o_h_clk_en, 0);
        chk("arst_h_active", o_h_active, 640);
        chk("arst_h_blank", o_h_blank, 799);
        chk("arst_v_blank", o_v_blank, 524);
        cyc(); cyc();
        i_rst = 1'b0;
        cyc();
        wr(4'd15, 12'd0);
        chk("def_commit_busy", o_cfg_busy, 1);
        cyc();
        chk("def_apply_busy", o_cfg_busy, 0);
        chk("def_apply_active", o_h_active, 640);

        repeat (3) cyc();
        chk("fs_pending", fs_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
